// File: rtl/au_pkg.sv
// Shared definitions for the arithmetic-unit dispatcher: opcodes, response
// error codes, FSM state encoding and default word geometry.
package au_pkg;

    localparam int W_DEF    = 24;
    localparam int FRAC_DEF = 14;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_TMO = 2'b01;
    localparam logic [1:0] ERR_DZ  = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_RESP  = 2'b11
    } state_e;

    // A divide whose divisor magnitude is zero is flagged; the sign bit is
    // ignored so that -0 is treated the same as +0.
    function automatic logic is_div_zero(input logic [1:0] op, input logic mag_zero);
        return (op == OP_DIV) && mag_zero;
    endfunction

endpackage

// File: rtl/au_dispatch_if.sv
// Request / AU / response bundle of the dispatcher. The slave modport is the
// dispatcher's view, the master modport is the surrounding system's view.
interface au_dispatch_if import au_pkg::*; #(parameter int W = W_DEF);

    logic           req_valid;
    logic           req_ready;
    logic [1:0]     req_op;
    logic [W-1:0]   req_r;
    logic [W-1:0]   req_s;
    logic [3:0]     req_tag;

    logic           au_start;
    logic [1:0]     au_ctl_d;
    logic [W-1:0]   au_R;
    logic [W-1:0]   au_S;
    logic [W-1:0]   au_I;
    logic [W-1:0]   au_result;
    logic           au_done;
    logic           au_busy;

    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_data;
    logic [3:0]     rsp_tag;
    logic [1:0]     rsp_err;

    logic           idle;

    modport slave (
        input  req_valid, req_op, req_r, req_s, req_tag,
        input  au_result, au_done, au_busy,
        input  rsp_ready,
        output req_ready,
        output au_start, au_ctl_d, au_R, au_S, au_I,
        output rsp_valid, rsp_data, rsp_tag, rsp_err,
        output idle
    );

    modport master (
        output req_valid, req_op, req_r, req_s, req_tag,
        output au_result, au_done, au_busy,
        output rsp_ready,
        input  req_ready,
        input  au_start, au_ctl_d, au_R, au_S, au_I,
        input  rsp_valid, rsp_data, rsp_tag, rsp_err,
        input  idle
    );

endinterface

// File: rtl/au_req_fifo.sv
// Request queue for the dispatcher. Entries are packed {op, r, s, tag}.
// The head entry is visible combinationally on pop_data_o (first-word
// fall-through); a push into an empty queue is only visible the next cycle.
module au_req_fifo import au_pkg::*; #(
    parameter int W     = W_DEF,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [2*W+5:0]   push_data_i,
    input  logic             pop_i,
    output logic [2*W+5:0]   pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q,  count_d;
    logic [2*W+5:0]  mem_q [DEPTH];
    logic [2*W+5:0]  mem_d [DEPTH];
    logic            push_s;
    logic            pop_s;

    assign full_o     = (count_q == (AW+1)'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign pop_data_o = mem_q[rd_ptr_q];

    // Next pointers, occupancy and storage contents
    always_comb begin
        push_s   = push_i && !full_o;
        pop_s    = pop_i && !empty_o;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset empties the queue
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care while the slot is unoccupied
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/au_dispatch.sv
// Dispatcher that queues arithmetic requests and feeds them one at a time to
// an external arithmetic unit, returning tagged responses in request order.
// A response carries the AU result, a timeout indication if the AU never
// completes, or a divide-by-zero flag alongside the AU's own output.
module au_dispatch import au_pkg::*; #(
    parameter int W       = W_DEF,
    parameter int FRAC    = FRAC_DEF,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    au_dispatch_if.slave bus
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic            fifo_pop_s;
    logic            fifo_push_s;
    logic [2*W+5:0]  fifo_wdata_s;
    logic [2*W+5:0]  fifo_rdata_s;
    logic [1:0]      head_op_s;
    logic [W-1:0]    head_r_s;
    logic [W-1:0]    head_s_s;
    logic [3:0]      head_tag_s;

    state_e          state_q,     state_d;
    logic [1:0]      op_q,        op_d;
    logic [W-1:0]    r_q,         r_d;
    logic [W-1:0]    s_q,         s_d;
    logic [3:0]      tag_q,       tag_d;
    logic            start_q,     start_d;
    logic [CW-1:0]   tmo_q,       tmo_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [W-1:0]    rsp_data_q,  rsp_data_d;
    logic [3:0]      rsp_tag_q,   rsp_tag_d;
    logic [1:0]      rsp_err_q,   rsp_err_d;

    assign fifo_push_s  = bus.req_valid && !fifo_full_s;
    assign fifo_wdata_s = {bus.req_op, bus.req_r, bus.req_s, bus.req_tag};
    assign head_op_s    = fifo_rdata_s[2*W+5 -: 2];
    assign head_r_s     = fifo_rdata_s[2*W+3 -: W];
    assign head_s_s     = fifo_rdata_s[W+3 -: W];
    assign head_tag_s   = fifo_rdata_s[3:0];

    au_req_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_req_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push_s),
        .push_data_i (fifo_wdata_s),
        .pop_i       (fifo_pop_s),
        .pop_data_o  (fifo_rdata_s),
        .full_o      (fifo_full_s),
        .empty_o     (fifo_empty_s)
    );

    // Next-state, issue latching, timeout counting and response capture
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        r_d         = r_q;
        s_d         = s_q;
        tag_d       = tag_q;
        start_d     = 1'b0;
        tmo_d       = tmo_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_tag_d   = rsp_tag_q;
        rsp_err_d   = rsp_err_q;
        fifo_pop_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Only registered FIFO occupancy is used here, so a push
                // into an empty queue never bypasses to the AU.
                if (!fifo_empty_s && !bus.au_busy) begin
                    fifo_pop_s = 1'b1;
                    op_d       = head_op_s;
                    r_d        = head_r_s;
                    s_d        = head_s_s;
                    tag_d      = head_tag_s;
                    start_d    = 1'b1;
                    state_d    = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                tmo_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.au_done) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = bus.au_result;
                    rsp_tag_d   = tag_q;
                    rsp_err_d   = is_div_zero(op_q, s_q[W-2:0] == '0) ? ERR_DZ : ERR_OK;
                    state_d     = ST_RESP;
                end else if (tmo_q == CW'(TIMEOUT - 1)) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_tag_d   = tag_q;
                    rsp_err_d   = ERR_TMO;
                    state_d     = ST_RESP;
                end else begin
                    tmo_d = tmo_q + CW'(1);
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, issue and response registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            r_q         <= '0;
            s_q         <= '0;
            tag_q       <= '0;
            start_q     <= 1'b0;
            tmo_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_tag_q   <= '0;
            rsp_err_q   <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            r_q         <= r_d;
            s_q         <= s_d;
            tag_q       <= tag_d;
            start_q     <= start_d;
            tmo_q       <= tmo_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.req_ready = !fifo_full_s;
    assign bus.au_start  = start_q;
    assign bus.au_ctl_d  = op_q;
    assign bus.au_R      = r_q;
    assign bus.au_S      = s_q;
    assign bus.au_I      = '0;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_tag   = rsp_tag_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.idle      = fifo_empty_s && (state_q == ST_IDLE) && !rsp_valid_q;

endmodule

// File: tb/tb_au_dispatch.sv
// Directed bench for au_dispatch: a vector table of single operations plus
// hand-written sequences for AU busy, queue back-pressure, timeout, late
// completion and reset during an in-flight operation.
module tb_au_dispatch;
    import au_pkg::*;

    localparam int W       = 24;
    localparam int FRAC    = 14;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;

    typedef struct {
        logic [1:0]  op;
        logic [23:0] r;
        logic [23:0] s;
        logic [3:0]  tag;
        logic [23:0] exp_data;
        logic [1:0]  exp_err;
    } vec_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_miss;

    // AU model state
    int          dly;
    logic [23:0] res;
    bit          never;
    bit          inj;
    logic [23:0] inj_result;

    au_dispatch_if #(.W(W)) bus ();

    au_dispatch #(
        .W       (W),
        .FRAC    (FRAC),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Sign-magnitude reference AU, Q(FRAC) fixed point
    function automatic logic [23:0] au_calc(input logic [1:0] op, input logic [23:0] r, input logic [23:0] s);
        logic        sr, ss, sg;
        logic [22:0] mr, ms, mg;
        logic [45:0] p;
        sr = r[23]; ss = s[23]; mr = r[22:0]; ms = s[22:0];
        sg = 1'b0; mg = '0; p = '0;
        case (op)
            OP_ADD, OP_SUB: begin
                if (op == OP_SUB) ss = ~ss;
                if (sr == ss) begin mg = mr + ms; sg = sr; end
                else if (mr >= ms) begin mg = mr - ms; sg = sr; end
                else begin mg = ms - mr; sg = ss; end
            end
            OP_MUL: begin
                p  = mr * ms;
                mg = p[36:14];
                sg = sr ^ ss;
            end
            default: begin
                if (ms == 23'd0) mg = 23'h7FFFFF;
                else begin p = {mr, 14'd0} / ms; mg = p[22:0]; end
                sg = sr ^ ss;
            end
        endcase
        if (mg == 23'd0) sg = 1'b0;
        return {sg, mg};
    endfunction

    // AU model: done pulse two cycles after the start pulse is seen
    initial begin
        bus.au_done   = 1'b0;
        bus.au_result = '0;
        dly = 0;
        res = '0;
        forever begin
            logic pulse;
            @(posedge clk);
            #1;
            pulse = (dly == 1);
            if (dly > 0) dly = dly - 1;
            if (bus.au_start && !never) begin
                dly = 2;
                res = au_calc(bus.au_ctl_d, bus.au_R, bus.au_S);
            end
            bus.au_done   = pulse | inj;
            bus.au_result = inj ? inj_result : res;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Present a request and hold it until accepted (returns at the negedge after acceptance)
    task automatic send(input logic [1:0] op, input logic [23:0] r, input logic [23:0] s, input logic [3:0] tag);
        bit rdy;
        rdy = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_op = op; bus.req_r = r; bus.req_s = s; bus.req_tag = tag;
        for (int k = 0; k < 300; k++) begin
            rdy = bus.req_ready;
            @(negedge clk);
            if (rdy) break;
        end
        if (!rdy) begin
            n_vec  = n_vec + 1;
            n_miss = n_miss + 1;
            $display("FAIL send_timeout tag %0d: req_ready stayed 0, required 1", tag);
        end
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!bus.rsp_valid && n < 500) begin
            @(negedge clk);
            n = n + 1;
        end
    endtask

    task automatic consume();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic run_op(input vec_t v, input bit chk_lat);
        int n;
        send(v.op, v.r, v.s, v.tag);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("au_start", bus.au_start, 1'b1);
        chk("au_operands", {bus.au_ctl_d, bus.au_R, bus.au_S}, {v.op, v.r, v.s});
        chk("au_I", bus.au_I, 24'h000000);
        wait_rsp(n);
        if (chk_lat) chk("latency", n + 1, 4);
        chk("rsp_valid", bus.rsp_valid, 1'b1);
        chk("rsp_data", bus.rsp_data, v.exp_data);
        chk("rsp_tag", bus.rsp_tag, v.tag);
        chk("rsp_err", bus.rsp_err, v.exp_err);
        consume();
        chk("rsp_cleared", bus.rsp_valid, 1'b0);
        chk("idle_after", bus.idle, 1'b1);
    endtask

    vec_t vecs [8];

    initial begin
        int n;
        n_vec = 0; n_miss = 0;
        never = 1'b0; inj = 1'b0; inj_result = '0;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_r = '0; bus.req_s = '0; bus.req_tag = '0;
        bus.au_busy = 1'b0; bus.rsp_ready = 1'b0;

        vecs[0] = '{OP_ADD, 24'h004000, 24'h008000, 4'd3,  24'h00C000, ERR_OK};
        vecs[1] = '{OP_MUL, 24'h806000, 24'h008000, 4'd1,  24'h80C000, ERR_OK};
        vecs[2] = '{OP_SUB, 24'h00C000, 24'h004000, 4'd2,  24'h008000, ERR_OK};
        vecs[3] = '{OP_SUB, 24'h004000, 24'h00C000, 4'd4,  24'h808000, ERR_OK};
        vecs[4] = '{OP_ADD, 24'h802000, 24'h006000, 4'd5,  24'h004000, ERR_OK};
        vecs[5] = '{OP_DIV, 24'h008000, 24'h004000, 4'd6,  24'h008000, ERR_OK};
        vecs[6] = '{OP_DIV, 24'h004000, 24'h000000, 4'd8,  24'h7FFFFF, ERR_DZ};
        vecs[7] = '{OP_DIV, 24'h00C000, 24'h800000, 4'd10, 24'hFFFFFF, ERR_DZ};

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 1'b1);
        chk("rst_idle", bus.idle, 1'b1);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_au_start", bus.au_start, 1'b0);
        chk("rst_au_regs", {bus.au_ctl_d, bus.au_R, bus.au_S}, 50'd0);
        chk("rst_rsp_regs", {bus.rsp_data, bus.rsp_tag, bus.rsp_err}, 30'd0);

        // Table of single operations
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i], vecs[i].op != OP_DIV);
        end

        // Divide by zero issued only once the AU stops reporting busy
        bus.au_busy = 1'b1;
        send(OP_DIV, 24'h004000, 24'h000000, 4'd11);
        bus.req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("busy_hold_start", bus.au_start, 1'b0);
            @(negedge clk);
        end
        chk("busy_not_idle", bus.idle, 1'b0);
        bus.au_busy = 1'b0;
        @(negedge clk);
        chk("busy_release_start", bus.au_start, 1'b1);
        wait_rsp(n);
        chk("dz_rsp_data", bus.rsp_data, 24'h7FFFFF);
        chk("dz_rsp_err", bus.rsp_err, ERR_DZ);
        chk("dz_rsp_tag", bus.rsp_tag, 4'd11);
        consume();

        // Six back-to-back requests with the response side stalled
        for (int i = 0; i < 5; i++) begin
            send(OP_ADD, 24'(i * 24'h004000), 24'h004000, 4'(i));
        end
        chk("full_after_5th", bus.req_ready, 1'b0);
        bus.req_op = OP_ADD; bus.req_r = 24'h014000; bus.req_s = 24'h004000; bus.req_tag = 4'd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_req_ready", bus.req_ready, 1'b0);
            chk("stall_rsp_valid", bus.rsp_valid, 1'b1);
            chk("stall_rsp_tag", bus.rsp_tag, 4'd0);
            chk("stall_rsp_data", bus.rsp_data, 24'h004000);
        end
        bus.rsp_ready = 1'b1;
        fork
            begin
                send(OP_ADD, 24'h014000, 24'h004000, 4'd5);
                bus.req_valid = 1'b0;
            end
            begin
                for (int i = 0; i < 6; i++) begin
                    int m;
                    wait_rsp(m);
                    chk("order_tag", bus.rsp_tag, 4'(i));
                    chk("order_data", bus.rsp_data, 24'((i + 1) * 24'h004000));
                    @(negedge clk);
                end
            end
        join
        bus.rsp_ready = 1'b0;
        chk("order_idle", bus.idle, 1'b1);

        // Timeout: AU never completes, later done pulses are ignored
        never = 1'b1;
        send(OP_ADD, 24'h004000, 24'h004000, 4'd7);
        bus.req_valid = 1'b0;
        @(negedge clk);
        chk("tmo_start", bus.au_start, 1'b1);
        wait_rsp(n);
        chk("tmo_wait_cycles", n - 1, TIMEOUT);
        chk("tmo_rsp_data", bus.rsp_data, 24'h000000);
        chk("tmo_rsp_err", bus.rsp_err, ERR_TMO);
        chk("tmo_rsp_tag", bus.rsp_tag, 4'd7);
        inj_result = 24'h123456;
        inj = 1'b1;
        @(negedge clk);
        inj = 1'b0;
        repeat (2) @(negedge clk);
        chk("late_done_data", bus.rsp_data, 24'h000000);
        chk("late_done_err", bus.rsp_err, ERR_TMO);
        chk("late_done_valid", bus.rsp_valid, 1'b1);
        consume();
        inj = 1'b1;
        @(negedge clk);
        inj = 1'b0;
        repeat (3) @(negedge clk);
        chk("spurious_done_valid", bus.rsp_valid, 1'b0);
        chk("spurious_done_idle", bus.idle, 1'b1);
        chk("spurious_done_start", bus.au_start, 1'b0);

        // Reset while an operation waits on the AU
        send(OP_MUL, 24'h004000, 24'h004000, 4'd9);
        bus.req_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre_rst_busy", bus.idle, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("mid_rst_idle", bus.idle, 1'b1);
        chk("mid_rst_req_ready", bus.req_ready, 1'b1);
        rst = 1'b0;
        never = 1'b0;
        n = 0;
        repeat (TIMEOUT + 10) begin
            @(negedge clk);
            if (bus.rsp_valid) n = n + 1;
        end
        chk("dropped_no_rsp", n, 0);

        // Normal operation resumes after reset
        run_op(vecs[0], 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/au_dispatch.md
AU_DISPATCH -- requirements
Module: au_dispatch

Interface
REQ-001 SHALL have parameter W, default 24, word width (sign-magnitude).
REQ-002 SHALL have parameter FRAC, default 14, fractional bits; passed through only, not used arithmetically.
REQ-003 SHALL have parameter DEPTH, default 4, request FIFO entries (power of 2).
REQ-004 SHALL have parameter TIMEOUT, default 64, maximum WAIT cycles before abandoning an op.
REQ-005 Ports SHALL be as follows.
- clk  in  1  sole clock; one clock domain.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high with req_valid.
- req_op  in  2  00=ADD, 01=SUB, 10=MUL, 11=DIV.
- req_r  in  W  operand R.
- req_s  in  W  operand S.
- req_tag  in  4  caller tag.
- au_start  out  1  one-cycle start pulse to AU.
- au_ctl_d  out  2  AU opcode.
- au_R  out  W  AU operand R.
- au_S  out  W  AU operand S.
- au_I  out  W  AU immediate; constant zero.
- au_result  in  W  AU result, valid while au_done high.
- au_done  in  1  AU completion pulse.
- au_busy  in  1  AU reciprocal in progress.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when high with rsp_valid.
- rsp_data  out  W  result word.
- rsp_tag  out  4  tag of the originating request.
- rsp_err  out  2  00=ok, 01=timeout, 10=divide-by-zero.
- idle  out  1  FIFO empty, FSM in IDLE, no response pending.

Function
REQ-006 Request FIFO SHALL have DEPTH entries {op, r, s, tag}; req_ready = !full, independent of a same-cycle pop; push on req_valid&&req_ready.
REQ-007 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-008 IDLE->ISSUE SHALL occur when FIFO non-empty and au_busy low; the FIFO SHALL pop on that edge and the entry SHALL be latched into issue registers.
REQ-009 In ISSUE, au_start SHALL be 1 for exactly one cycle; ISSUE->WAIT SHALL be unconditional.
REQ-010 au_ctl_d, au_R and au_S SHALL come from the issue registers and hold stable from ISSUE until the next ISSUE.
REQ-011 In WAIT, au_done=1 SHALL capture au_result, tag and err into the response register and transition to RESP.
REQ-012 err SHALL be 10 when op=DIV and req_s[W-2:0]==0; the AU result SHALL be passed through unmodified.
REQ-013 WAIT SHALL count cycles; if TIMEOUT cycles elapse without au_done, the block SHALL respond data=0, err=01 and transition to RESP.
REQ-014 rsp_valid SHALL be high exactly in RESP; RESP->IDLE SHALL occur on rsp_ready; the response SHALL hold stable until consumed.
REQ-015 au_done seen outside WAIT (late or spurious) SHALL be ignored.
REQ-016 Responses SHALL return in request order; at most one op SHALL be in flight.
REQ-017 Latency for ADD/SUB/MUL SHALL be: accept edge E0 -> au_start high after E1 -> rsp_valid high after E4 (AU done on E3).
REQ-018 Simultaneous push to an empty FIFO and an IDLE FSM SHALL NOT bypass the FIFO; the pop occurs on the next edge.

Reset
REQ-019 rst SHALL clear the FIFO (pointers and count), set FSM to IDLE, clear the timeout counter, and zero au_start, au_ctl_d, au_R, au_S, rsp_valid, rsp_data, rsp_tag and rsp_err; req_ready=1 and idle=1 the cycle after.
REQ-020 A reset mid-operation SHALL drop the in-flight op without a response; the first post-reset issue SHALL wait for au_busy low (REQ-008).

Structure
REQ-021 Shared package au_pkg SHALL hold:
- opcode constants OP_ADD, OP_SUB, OP_MUL, OP_DIV;
- error codes ERR_OK, ERR_TMO, ERR_DZ;
- default W and FRAC.
REQ-022 The FIFO SHALL be one sub-module, au_req_fifo (parameters W, DEPTH), instantiated once.

Verification
REQ-023 ADD 0x004000 + 0x008000, tag 3 -> rsp_data 0x00C000, tag 3, err 00; rsp_valid 4 cycles after accept.
REQ-024 MUL 0x806000 * 0x008000 -> rsp_data 0x80C000, err 00.
REQ-025 DIV 0x004000 / 0x000000 -> err 10; rsp_data equals the AU output; au_start waits for au_busy low.
REQ-026 Six back-to-back requests, tags 0..5, rsp_ready held low -> req_ready drops after the 5th accept; with rsp_ready high, tags 0..5 return in order.
REQ-027 AU model never asserts au_done -> rsp err 01, data 0, exactly TIMEOUT WAIT cycles after ISSUE; an au_done injected later is ignored.
REQ-028 rst asserted during WAIT -> next cycle rsp_valid=0, idle=1, FIFO empty; no response for the dropped tag.
